// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encodings,
// default parameters and the canonical NOP word.
package inst_fetch_unit_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned QDEPTH_DEF   = 2;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP          = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_DROP = 3'd3,
      ST_HALT = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of {pc, inst} pairs; the head entry is visible
// combinationally. Flush clears all entries and wins over push/pop.
module inst_fetch_unit_fetch_queue #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned QDEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [XLEN-1:0]              push_inst,
   input  logic [XLEN-1:0]              push_pc,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(QDEPTH):0]      count,
   output logic [XLEN-1:0]              head_inst,
   output logic [XLEN-1:0]              head_pc
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] inst_mem_r [QDEPTH];
   logic [XLEN-1:0] pc_mem_r   [QDEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            do_push_s;
   logic            do_pop_s;

   assign full      = (count_r == CW'(QDEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign head_inst = inst_mem_r[rd_ptr_r];
   assign head_pc   = pc_mem_r[rd_ptr_r];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_r + AW'(do_push_s);
         rd_ptr_r <= rd_ptr_r + AW'(do_pop_s);
         count_r  <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Entry storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         inst_mem_r[wr_ptr_r] <= push_inst;
         pc_mem_r[wr_ptr_r]   <= push_pc;
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one outstanding word read at a
// time under queue credit, and handles redirect flushes and sticky halt.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int unsigned     QDEPTH   = QDEPTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt
);

   localparam int unsigned CW   = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] QD_C = CW'(QDEPTH);

   fetch_state_e    state_r;
   fetch_state_e    state_s;
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] fetch_pc_s;
   logic            halted_r;
   logic            halt_now_s;
   logic            redir_s;
   logic            push_s;
   logic            pop_s;
   logic            credit_s;
   logic            full_s;
   logic            empty_s;
   logic [CW-1:0]   count_s;
   logic [CW-1:0]   count_next_s;
   logic [XLEN-1:0] head_inst_s;
   logic [XLEN-1:0] head_pc_s;

   // Halt beats redirect in the same cycle, and a halted unit ignores redirects.
   assign halt_now_s   = halt | halted_r;
   assign redir_s      = redirect_valid & ~halt_now_s & (state_r != ST_HALT);
   assign push_s       = (state_r == ST_WAIT) & imem_resp_valid & ~redir_s & (~full_s | pop_s);
   assign pop_s        = inst_ready & ~empty_s & ~redir_s;
   assign count_next_s = redir_s ? {CW{1'b0}} : (count_s + CW'(push_s) - CW'(pop_s));
   assign credit_s     = (count_next_s < QD_C);

   inst_fetch_unit_fetch_queue #(
      .XLEN   (XLEN),
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .pop       (pop_s),
      .flush     (redir_s),
      .push_inst (imem_resp_data),
      .push_pc   (fetch_pc_r),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count_s),
      .head_inst (head_inst_s),
      .head_pc   (head_pc_s)
   );

   // Next-state and next fetch PC.
   always_comb begin
      state_s    = state_r;
      fetch_pc_s = fetch_pc_r;
      if (redir_s) begin
         fetch_pc_s = redirect_pc & ~XLEN'(2'd3);
      end else if (push_s) begin
         fetch_pc_s = fetch_pc_r + XLEN'(3'd4);
      end else begin
         fetch_pc_s = fetch_pc_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (redir_s)         state_s = ST_IDLE;
            else if (halt_now_s) state_s = ST_HALT;
            else if (credit_s)   state_s = ST_REQ;
            else                 state_s = ST_IDLE;
         end
         ST_REQ: begin
            // Without acceptance the request can be retracted; once accepted its response must be dropped.
            if (redir_s)             state_s = imem_req_ready ? ST_DROP : ST_IDLE;
            else if (imem_req_ready) state_s = ST_WAIT;
            else if (halt_now_s)     state_s = ST_HALT;
            else                     state_s = ST_REQ;
         end
         ST_WAIT, ST_DROP: begin
            if (imem_resp_valid) begin
               if (halt_now_s)    state_s = ST_HALT;
               else if (credit_s) state_s = ST_REQ;
               else               state_s = ST_IDLE;
            end else if (redir_s) begin
               state_s = ST_DROP;
            end else begin
               state_s = state_r;
            end
         end
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM, fetch PC and sticky halt registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         fetch_pc_r <= RESET_PC & ~XLEN'(2'd3);
         halted_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         fetch_pc_r <= fetch_pc_s;
         halted_r   <= halted_r | halt;
      end
   end

   assign imem_req_valid = (state_r == ST_REQ);
   assign imem_req_addr  = (state_r == ST_REQ) ? fetch_pc_r : {XLEN{1'b0}};
   assign inst_valid     = ~empty_s;
   assign inst           = empty_s ? {XLEN{1'b0}} : head_inst_s;
   assign inst_pc        = empty_s ? {XLEN{1'b0}} : head_pc_s;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a variable-latency
// instruction memory model and a pop monitor.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt = 1'b0;

   int checks = 0;
   int errors = 0;
   int lat = 1;

   logic [31:0] mem [256];
   logic        pend;
   int          cnt;
   logic [7:0]  pend_idx;
   logic [31:0] got_pc [$];
   logic [31:0] got_inst [$];

   inst_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .halt            (halt)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
   end

   // Memory model: response 'lat' cycles after acceptance; in-flight response lost on reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_resp_valid <= 1'b0;
         imem_resp_data  <= 32'h0;
         pend            <= 1'b0;
         cnt             <= 0;
         pend_idx        <= 8'h0;
      end else begin
         imem_resp_valid <= 1'b0;
         if (pend) begin
            if (cnt == 1) begin
               imem_resp_valid <= 1'b1;
               imem_resp_data  <= mem[pend_idx];
               pend            <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            if (lat == 1) begin
               imem_resp_valid <= 1'b1;
               imem_resp_data  <= mem[imem_req_addr[9:2]];
            end else begin
               pend     <= 1'b1;
               cnt      <= lat - 1;
               pend_idx <= imem_req_addr[9:2];
            end
         end
      end
   end

   // Pop monitor.
   always @(posedge clk) begin
      if (!reset && inst_valid && inst_ready && !redirect_valid) begin
         got_pc.push_back(inst_pc);
         got_inst.push_back(inst);
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      halt = 1'b0;
      repeat (2) @(negedge clk);
      got_pc.delete();
      got_inst.delete();
      reset = 1'b0;
   endtask

   task automatic wait_pops(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (got_pc.size() >= n) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (imem_req_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_resp(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (imem_resp_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: got %h expected 0", imem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
   endtask

   task automatic test_sequential();
      bit ok;
      logic [31:0] exp_pc [4];
      logic [31:0] exp_inst [4];
      exp_pc   = '{32'h0, 32'h4, 32'h8, 32'hC};
      exp_inst = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      do_reset();
      wait_resp(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_resp_timeout: got none expected response"); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_lat_n: got %b expected 0", inst_valid); end
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL seq_lat_n1: got v=%b pc=%h expected v=1 pc=0", inst_valid, inst_pc); end
      wait_pops(4, 40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_pop_timeout: got %0d pops expected 4", got_pc.size()); end
      if (got_pc.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (got_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, got_pc[i], exp_pc[i]); end
            checks++; if (got_inst[i] !== exp_inst[i]) begin errors++; $display("FAIL seq_inst%0d: got %h expected %h", i, got_inst[i], exp_inst[i]); end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int req_high;
      lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
      do_reset();
      req_high = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req_valid) req_high++;
      end
      checks++; if (dut.count_s !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", dut.count_s); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b expected 0", imem_req_valid); end
      checks++; if (req_high != 2) begin errors++; $display("FAIL bp_req_cycles: got %0d expected 2", req_high); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", inst_valid, inst_pc); end
      inst_ready = 1'b1;
      wait_pops(2, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_pop_timeout: got %0d pops expected 2", got_pc.size()); end
      if (got_pc.size() >= 2) begin
         checks++; if (got_pc[0] !== 32'h0 || got_inst[0] !== 32'hA000_0000) begin errors++; $display("FAIL bp_first: got %h/%h expected 0/a0000000", got_pc[0], got_inst[0]); end
         checks++; if (got_pc[1] !== 32'h4 || got_inst[1] !== 32'hA000_0001) begin errors++; $display("FAIL bp_second: got %h/%h expected 4/a0000001", got_pc[1], got_inst[1]); end
      end
   endtask

   task automatic test_redirect_wait();
      bit ok;
      lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b0;
      do_reset();
      wait_req(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rw_req_timeout: got none expected request"); end
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_req(20, ok);
      checks++; if (!ok || imem_req_addr !== 32'h100) begin errors++; $display("FAIL rw_req_addr: got %h expected 00000100", imem_req_addr); end
      inst_ready = 1'b1;
      wait_pops(1, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rw_pop_timeout: got %0d pops expected 1", got_pc.size()); end
      if (got_pc.size() >= 1) begin
         checks++; if (got_pc[0] !== 32'h100 || got_inst[0] !== 32'hA000_0040) begin errors++; $display("FAIL rw_first: got %h/%h expected 100/a0000040", got_pc[0], got_inst[0]); end
      end
   endtask

   task automatic test_retract();
      bit ok;
      lat = 1; imem_req_ready = 1'b0; inst_ready = 1'b0;
      do_reset();
      wait_req(10, ok);
      checks++; if (!ok || imem_req_addr !== 32'h0) begin errors++; $display("FAIL rt_first_addr: got %h expected 0", imem_req_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rt_retract: got %b expected 0", imem_req_valid); end
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      wait_req(10, ok);
      checks++; if (!ok || imem_req_addr !== 32'h200) begin errors++; $display("FAIL rt_new_addr: got %h expected 00000200", imem_req_addr); end
      inst_ready = 1'b1;
      wait_pops(1, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rt_pop_timeout: got %0d pops expected 1", got_pc.size()); end
      if (got_pc.size() >= 1) begin
         checks++; if (got_pc[0] !== 32'h200 || got_inst[0] !== 32'hA000_0080) begin errors++; $display("FAIL rt_first: got %h/%h expected 200/a0000080", got_pc[0], got_inst[0]); end
      end
   endtask

   task automatic test_halt();
      bit ok;
      int req_high;
      lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b0;
      do_reset();
      wait_resp(20, ok);
      wait_req(10, ok);
      checks++; if (!ok || imem_req_addr !== 32'h4) begin errors++; $display("FAIL ht_second_req: got %h expected 4", imem_req_addr); end
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (4) @(negedge clk);
      inst_ready = 1'b1;
      wait_pops(2, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ht_pop_timeout: got %0d pops expected 2", got_pc.size()); end
      if (got_pc.size() >= 2) begin
         checks++; if (got_pc[0] !== 32'h0 || got_inst[0] !== 32'hA000_0000) begin errors++; $display("FAIL ht_first: got %h/%h expected 0/a0000000", got_pc[0], got_inst[0]); end
         checks++; if (got_pc[1] !== 32'h4 || got_inst[1] !== 32'hA000_0001) begin errors++; $display("FAIL ht_second: got %h/%h expected 4/a0000001", got_pc[1], got_inst[1]); end
      end
      req_high = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req_valid) req_high++;
      end
      checks++; if (req_high != 0) begin errors++; $display("FAIL ht_no_req: got %0d request cycles expected 0", req_high); end
      checks++; if (got_pc.size() != 2) begin errors++; $display("FAIL ht_pop_total: got %0d expected 2", got_pc.size()); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ht_empty: got %b expected 0", inst_valid); end
   endtask

   task automatic test_async_reset();
      bit ok;
      lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b0;
      do_reset();
      wait_resp(20, ok);
      wait_req(10, ok);
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", inst_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL ar_outputs: got v=%b i=%h pc=%h expected zeros", inst_valid, inst, inst_pc); end
      checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL ar_req: got v=%b a=%h expected zeros", imem_req_valid, imem_req_addr); end
      #1 reset = 1'b0;
      got_pc.delete();
      got_inst.delete();
      @(negedge clk);
      inst_ready = 1'b1;
      wait_pops(1, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ar_pop_timeout: got %0d pops expected 1", got_pc.size()); end
      if (got_pc.size() >= 1) begin
         checks++; if (got_pc[0] !== 32'h0 || got_inst[0] !== 32'hA000_0000) begin errors++; $display("FAIL ar_restart: got %h/%h expected 0/a0000000", got_pc[0], got_inst[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_retract();
      test_halt();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
